// File: rtl/count_display_mux_pkg.sv
// Shared types and constants for the count display stage: FSM states,
// seven-segment patterns (active low, g..a) and digit count.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/count_display_mux_if.sv
// Count inputs and display pins of the count display stage.
// No handshake: counts are sampled as levels in IDLE, outputs are free-running.
interface count_display_mux_if;
    import count_display_pkg::*;

    logic [7:0]        i_count_a;
    logic [7:0]        i_count_b;
    logic [DIGITS-1:0] o_an;
    logic [7:0]        o_sseg;
    logic              o_busy;
    state_t            dbg_state;

    modport master (
        output i_count_a, i_count_b,
        input  o_an, o_sseg, o_busy, dbg_state
    );

    modport slave (
        input  i_count_a, i_count_b,
        output o_an, o_sseg, o_busy, dbg_state
    );

endinterface

// File: rtl/count_display_mux_bin2bcd_step.sv
// Add-3 correction of a 3-digit BCD value, applied before each
// shift-left step of the binary-to-BCD conversion.
module bin2bcd_step (
    input  logic [11:0] bcd,
    output logic [11:0] bcd_adj
);

    for (genvar i = 0; i < 3; i++) begin : g_nib
        assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                            : bcd[4*i +: 4];
    end

endmodule

// File: rtl/count_display_mux.sv
// Converts two 8-bit counts to BCD (IDLE, 8x SHIFT, DONE) and scans them
// onto an 8-digit multiplexed seven-segment display.
module count_display_mux
    import count_display_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b1
) (
    input logic                i_clk,
    input logic                i_rst_n,
    count_display_mux_if.slave bus
);

    state_t                  state, state_next;
    logic [7:0]              bin_a, bin_b;
    logic [11:0]             bcd_a, bcd_b;
    logic [11:0]             bcd_a_adj, bcd_b_adj;
    logic [11:0]             disp_a, disp_b;
    logic [2:0]              iter;
    logic [REFRESH_BITS-1:0] refresh;
    logic [2:0]              sel;
    logic [11:0]             disp;
    logic [3:0]              nib;
    logic                    blank;
    logic [7:0]              sseg_next, sseg_q;
    logic [DIGITS-1:0]       an_next, an_q;

    bin2bcd_step u_step_a (.bcd(bcd_a), .bcd_adj(bcd_a_adj));
    bin2bcd_step u_step_b (.bcd(bcd_b), .bcd_adj(bcd_b_adj));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SHIFT;
            SHIFT:   if (iter == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Display registers change only in DONE, so a partial result is never shown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_a  <= '0;
            bin_b  <= '0;
            bcd_a  <= '0;
            bcd_b  <= '0;
            iter   <= '0;
            disp_a <= '0;
            disp_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bin_a <= bus.i_count_a;
                    bin_b <= bus.i_count_b;
                    bcd_a <= '0;
                    bcd_b <= '0;
                    iter  <= '0;
                end
                SHIFT: begin
                    {bcd_a, bin_a} <= {bcd_a_adj, bin_a} << 1;
                    {bcd_b, bin_b} <= {bcd_b_adj, bin_b} << 1;
                    iter           <= iter + 3'd1;
                end
                DONE: begin
                    disp_a <= bcd_a;
                    disp_b <= bcd_b;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
        end
    end

    assign sel  = refresh[REFRESH_BITS-1 -: 3];
    assign disp = sel[2] ? disp_b : disp_a;

    always_comb begin
        nib   = disp[3:0];
        blank = 1'b0;
        case (sel[1:0])
            2'd0: nib = disp[3:0];
            2'd1: begin
                nib   = disp[7:4];
                blank = BLANK_LZ && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = disp[11:8];
                blank = BLANK_LZ && (disp[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        // Blank digits keep their anode on so every digit gets equal scan time.
        sseg_next = blank ? 8'hFF : {1'b1, seg_decode(nib)};
        an_next   = ~(DIGITS'(1) << sel);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            an_q   <= '1;
            sseg_q <= 8'hFF;
        end else begin
            an_q   <= an_next;
            sseg_q <= sseg_next;
        end
    end

    assign bus.o_an      = an_q;
    assign bus.o_sseg    = sseg_q;
    assign bus.o_busy    = (state != IDLE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_count_display_mux.sv
// Bench for count_display_mux: two instances (leading-zero blanking on/off)
// compared each cycle against a decimal-digit schedule model.
module tb_count_display_mux;
    import count_display_pkg::*;

    localparam int RB = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] count_a = 8'd0;
    logic [7:0] count_b = 8'd0;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    count_display_mux_if bus1 ();
    count_display_mux_if bus0 ();

    assign bus1.i_count_a = count_a;
    assign bus1.i_count_b = count_b;
    assign bus0.i_count_a = count_a;
    assign bus0.i_count_b = count_b;

    count_display_mux #(.REFRESH_BITS(RB), .BLANK_LZ(1'b1)) dut_lz (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );
    count_display_mux #(.REFRESH_BITS(RB), .BLANK_LZ(1'b0)) dut_nolz (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] seg_of(input int d);
        logic [7:0] tab [10];
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tab[d];
    endfunction

    function automatic logic [7:0] exp_digit(input int v, input int pos, input bit lz);
        int hund, tens, ones;
        hund = v / 100;
        tens = (v / 10) % 10;
        ones = v % 10;
        case (pos)
            0:       return seg_of(ones);
            1:       return (lz && hund == 0 && tens == 0) ? 8'hFF : seg_of(tens);
            2:       return (lz && hund == 0) ? 8'hFF : seg_of(hund);
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_sseg(input int s, input int a, input int b, input bit lz);
        return (s < 4) ? exp_digit(a, s, lz) : exp_digit(b, s - 4, lz);
    endfunction

    // Edge n after reset release: capture when n%10==1, display when n%10==0.
    int         m_n;
    int         nn;
    int         m_samp_a, m_samp_b, m_disp_a, m_disp_b;
    int         e_sel;
    logic [7:0] e_an, e_sseg1, e_sseg0;
    logic       e_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      <= 0;
            m_samp_a <= 0;
            m_samp_b <= 0;
            m_disp_a <= 0;
            m_disp_b <= 0;
            e_sel    <= 0;
            e_an     <= 8'hFF;
            e_sseg1  <= 8'hFF;
            e_sseg0  <= 8'hFF;
            e_busy   <= 1'b0;
        end else begin
            nn = m_n + 1;
            e_sel   <= (m_n / 8) % 8;
            e_an    <= 8'hFF ^ (8'd1 << ((m_n / 8) % 8));
            e_sseg1 <= exp_sseg((m_n / 8) % 8, m_disp_a, m_disp_b, 1'b1);
            e_sseg0 <= exp_sseg((m_n / 8) % 8, m_disp_a, m_disp_b, 1'b0);
            e_busy  <= (nn % 10) != 0;
            if (nn % 10 == 1) begin
                m_samp_a <= int'(count_a);
                m_samp_b <= int'(count_b);
            end
            if (nn % 10 == 0) begin
                m_disp_a <= m_samp_a;
                m_disp_b <= m_samp_b;
            end
            m_n <= nn;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        count_a = 8'($urandom_range(0, 255));
        count_b = 8'($urandom_range(0, 255));
        rst_n   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (bus1.o_an !== 8'hFF || bus1.o_sseg !== 8'hFF || bus1.o_busy !== 1'b0 || bus1.dbg_state !== IDLE)
                $display("FAIL reset_lz an=%h sseg=%h busy=%b st=%0d expected FF FF 0 0",
                         bus1.o_an, bus1.o_sseg, bus1.o_busy, bus1.dbg_state);
            else n_pass++;
            n_checks++;
            if (bus0.o_an !== 8'hFF || bus0.o_sseg !== 8'hFF || bus0.o_busy !== 1'b0)
                $display("FAIL reset_nolz an=%h sseg=%h busy=%b expected FF FF 0",
                         bus0.o_an, bus0.o_sseg, bus0.o_busy);
            else n_pass++;
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus1.o_busy !== 1'b0) $display("FAIL release_busy_low got %b expected 0", bus1.o_busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus1.o_busy !== 1'b1 || bus0.o_busy !== 1'b1)
            $display("FAIL release_busy_rise got %b/%b expected 1", bus1.o_busy, bus0.o_busy);
        else n_pass++;
        n_checks++;
        if (bus1.o_an !== e_an || bus1.o_sseg !== e_sseg1)
            $display("FAIL release_first got an=%h sseg=%h expected an=%h sseg=%h",
                     bus1.o_an, bus1.o_sseg, e_an, e_sseg1);
        else n_pass++;
    endtask

    task automatic test_table(input int a, input int b,
                              input logic [7:0] t1 [8], input logic [7:0] t0 [8]);
        count_a = 8'(a);
        count_b = 8'(b);
        repeat (20) @(negedge clk);
        repeat (64) begin
            @(negedge clk);
            n_checks++;
            if (bus1.o_an !== e_an || bus1.o_sseg !== t1[e_sel])
                $display("FAIL table_lz a=%0d b=%0d sel=%0d got an=%h sseg=%h expected an=%h sseg=%h",
                         a, b, e_sel, bus1.o_an, bus1.o_sseg, e_an, t1[e_sel]);
            else n_pass++;
            n_checks++;
            if (bus0.o_an !== e_an || bus0.o_sseg !== t0[e_sel])
                $display("FAIL table_nolz a=%0d b=%0d sel=%0d got an=%h sseg=%h expected an=%h sseg=%h",
                         a, b, e_sel, bus0.o_an, bus0.o_sseg, e_an, t0[e_sel]);
            else n_pass++;
        end
    endtask

    task automatic test_change_mid();
        bit found;
        count_a = 8'd37;
        count_b = 8'($urandom_range(0, 255));
        repeat (20) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (m_n % 10 == 1) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL change_sync no capture edge within 12 cycles");
        else n_pass++;
        count_a = 8'd200;
        repeat (40) begin
            @(negedge clk);
            n_checks++;
            if (bus1.o_an !== e_an || bus1.o_sseg !== e_sseg1 || bus1.o_busy !== e_busy)
                $display("FAIL change_mid got an=%h sseg=%h busy=%b expected an=%h sseg=%h busy=%b",
                         bus1.o_an, bus1.o_sseg, bus1.o_busy, e_an, e_sseg1, e_busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        count_a = 8'd123;
        count_b = 8'd45;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (m_n % 10 == 5) found = 1'b1;
        end
        n_checks++;
        if (!found || bus1.o_busy !== 1'b1)
            $display("FAIL reset_mid_sync found=%b busy=%b expected 1 1", found, bus1.o_busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus1.o_an !== 8'hFF || bus1.o_sseg !== 8'hFF || bus1.o_busy !== 1'b0 || bus1.dbg_state !== IDLE)
            $display("FAIL reset_mid_now an=%h sseg=%h busy=%b st=%0d expected FF FF 0 0",
                     bus1.o_an, bus1.o_sseg, bus1.o_busy, bus1.dbg_state);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) begin
            @(negedge clk);
            n_checks++;
            if (bus1.o_an !== e_an || bus1.o_sseg !== e_sseg1 || bus1.o_busy !== e_busy)
                $display("FAIL reset_mid_after got an=%h sseg=%h busy=%b expected an=%h sseg=%h busy=%b",
                         bus1.o_an, bus1.o_sseg, bus1.o_busy, e_an, e_sseg1, e_busy);
            else n_pass++;
            n_checks++;
            if (bus0.o_sseg !== e_sseg0)
                $display("FAIL reset_mid_after_nolz got sseg=%h expected %h", bus0.o_sseg, e_sseg0);
            else n_pass++;
        end
    endtask

    task automatic test_scan();
        repeat (64) begin
            @(negedge clk);
            n_checks++;
            if (bus1.o_an !== e_an)
                $display("FAIL scan_walk got %h expected %h", bus1.o_an, e_an);
            else n_pass++;
            n_checks++;
            if ($countones(~bus1.o_an) != 1)
                $display("FAIL scan_onehot got %h expected one low bit", bus1.o_an);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 15; it++) begin
            count_a = 8'($urandom_range(0, 255));
            count_b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(3, 30)) begin
                @(negedge clk);
                n_checks++;
                if (bus1.o_an !== e_an || bus1.o_sseg !== e_sseg1 || bus1.o_busy !== e_busy)
                    $display("FAIL random_lz got an=%h sseg=%h busy=%b expected an=%h sseg=%h busy=%b",
                             bus1.o_an, bus1.o_sseg, bus1.o_busy, e_an, e_sseg1, e_busy);
                else n_pass++;
                n_checks++;
                if (bus0.o_an !== e_an || bus0.o_sseg !== e_sseg0 || bus0.o_busy !== e_busy)
                    $display("FAIL random_nolz got an=%h sseg=%h busy=%b expected an=%h sseg=%h busy=%b",
                             bus0.o_an, bus0.o_sseg, bus0.o_busy, e_an, e_sseg0, e_busy);
                else n_pass++;
            end
        end
    endtask

    initial begin
        logic [7:0] t1 [8];
        logic [7:0] t0 [8];
        test_reset();
        t1 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'h92, 8'hA4, 8'hFF};
        t0 = '{8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'h92, 8'h92, 8'hA4, 8'hFF};
        test_table(0, 255, t1, t0);
        t1 = '{8'h90, 8'hC0, 8'hF9, 8'hFF, 8'hC0, 8'hF9, 8'hFF, 8'hFF};
        t0 = '{8'h90, 8'hC0, 8'hF9, 8'hFF, 8'hC0, 8'hF9, 8'hC0, 8'hFF};
        test_table(109, 10, t1, t0);
        test_change_mid();
        test_reset_mid();
        test_scan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
